timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  Memory-mapped programmable down-counter; one of the interrupt sources feeding the CP0 HWInt[5:0] inputs.
//  The CPU bridge writes and reads three 32-bit registers through a word-addressed port.
//  In mode 0 the block raises a sticky IRQ when the count reaches zero. In mode 1 it auto-reloads and pulses IRQ.
//  IRQ drives one HWInt bit directly. CP0 masks it with SR[15:10]; this block does no gating towards CP0.
// PARAMETERS
//  CNT_W  32  width of PRESET/COUNT; Dout zero-extends to 32 bits; Din[CNT_W-1:0] used on write
// PORTS
//  clk    in   1   single clock, all state updates on posedge
//  reset  in   1   asynchronous, active-high; clears all state immediately
//  Addr   in   2   word offset (CPU byte addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS
//  WE     in   1   write strobe, sampled at posedge
//  Din    in   32  write data
//  Dout   out  32  combinational read data for Addr
//  IRQ    out  1   interrupt request = irq_flag & CTRL.IM
// BEHAVIOUR
//  CTRL[3:0] = {IM, Mode[1:0], En}; other bits read 0. Mode 2/3 behave as mode 0.
//  Reset (async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE; so IRQ=0 and Dout follows Addr with zeroed regs.
//  FSM states: IDLE, LOAD, CNT, INT.
//   IDLE: En=1 -> LOAD; else stay.
//   LOAD: COUNT<=PRESET; -> CNT.
//   CNT : En=0 -> IDLE, COUNT holds; COUNT==0 -> INT, irq_flag<=1; else COUNT<=COUNT-1.
//   INT : mode0 -> CTRL.En<=0, -> IDLE, irq_flag stays 1 (sticky).
//         mode1 -> irq_flag<=0 (exactly 1-cycle pulse), -> LOAD.
//  Timing: CTRL write with En=1 at edge E0 and PRESET=N gives:
//   COUNT=N after E2; COUNT=0 after E(N+2); irq_flag=1 after E(N+3).
//   Mode 1 period is N+3 cycles.
//  Writes:
//   CTRL write stores Din[3:0]. A CTRL write with En=1 also clears irq_flag.
//   PRESET write stores Din; takes effect only at the next LOAD.
//   COUNT is read-only; writes to COUNT are ignored.
//  Simultaneous events:
//   CPU CTRL write in the same cycle as the INT auto-clear of En: the CPU value wins.
//   irq_flag set (CNT->INT) and clear (CTRL write En=1) in the same cycle: set wins.
//  IM=0 masks IRQ only; irq_flag still sets and stays readable via STATUS when the feature is enabled.
//  En cleared mid-count: COUNT frozen, FSM goes to IDLE. Re-enabling reloads PRESET (no resume).
//  PRESET=0: LOAD->CNT->INT; irq_flag=1 after E3.
//  COUNT never wraps below 0.
//  Reset asserted mid-count: everything is zeroed that cycle; IRQ drops without waiting for clk.
// CONFIGURATION
//  TC_STATUS_EN defined:
//   Addr 3 reads {31'b0, irq_flag}.
//   Writing Addr 3 with Din[0]=1 clears irq_flag (W1C). Same-cycle set still wins.
//  TC_STATUS_EN undefined:
//   Addr 3 reads 0 and writes are ignored.
//   irq_flag is cleared only by a CTRL write with En=1, or by reset.
// TESTING
//  1 Reset: assert reset between edges -> IRQ=0 and Dout=0 for Addr 0..3 before the next posedge.
//  2 Mode0: PRESET=5, CTRL=0x9 at E0 -> COUNT 5,4,..,0 after E2..E7; IRQ=1 after E8 and held.
//    CTRL reads 0x8; COUNT stays 0.
//  3 Mode1: PRESET=3, CTRL=0xB -> IRQ pulses 1 cycle, first after E6, then every 6 cycles; COUNT reloads to 3.
//  4 Pause/mask: CTRL=0x1 (IM=0), PRESET=10, clear En at COUNT=4 -> COUNT frozen at 4, IRQ=0.
//    Re-enable -> COUNT=10 two cycles later.
//  5 Collision: in mode0, write CTRL=0x9 in the INT cycle -> En stays 1, counting restarts, irq_flag remains 1.
//  6 TC_STATUS_EN: after a mode0 expiry, read Addr3=1; write Addr3=1 -> IRQ=0 next cycle.
//    Writes to Addr2 leave COUNT unchanged.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with sticky (mode 0) or auto-reload pulsed (mode 1) IRQ.
// Optional macro TC_STATUS_EN adds a readable, write-1-to-clear STATUS register at word 3.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;
    logic             mode1;
    logic             hold;
    logic [31:0]      status;
    assign mode1 = ctrl[2:1] == 2'b01;
    // a flag being set (or held sticky in the mode-0 INT cycle) beats any CPU clear
    assign hold = (state == CNT && ctrl[0] && count == '0) || (state == INT && !mode1);
`ifdef TC_STATUS_EN
    assign status = {31'b0, irq_flag};
`else
    assign status = '0;
`endif
    assign Dout = Addr == 2'd0 ? {28'b0, ctrl} :
                  Addr == 2'd1 ? 32'(preset) :
                  Addr == 2'd2 ? 32'(count) : status;
    assign IRQ = irq_flag & ctrl[3];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) state <= IDLE;
                    else if (count == '0) begin
                        state    <= INT;
                        irq_flag <= 1'b1;
                    end else count <= count - CNT_W'(1);
                end
                INT: begin
                    if (mode1) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // CPU writes come last so they override the FSM's auto-clear of En
            if (WE && Addr == 2'd0) begin
                ctrl <= Din[3:0];
                if (Din[0] && !hold) irq_flag <= 1'b0;
            end
            if (WE && Addr == 2'd1) preset <= Din[CNT_W-1:0];
`ifdef TC_STATUS_EN
            if (WE && Addr == 2'd3 && Din[0] && !hold) irq_flag <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter; expectations come from a timeline-based reference model.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    timer_counter dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] dout;
        logic        irq;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // reference model: the run is described by the edge of the last load and elapsed edges since then
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    bit          m_flag;
    longint      e, arm, ld, n;

    task automatic model_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0;
        arm = -1; ld = -1; n = 0;
    endtask

    task automatic model_step();
        bit     hold = 0;
        bit     en = m_ctrl[0];
        bit     md1 = m_ctrl[2:1] == 2'b01;
        longint el;
        e++;
        if (arm == e) begin
            n = longint'(m_preset); ld = e; arm = -1; m_count = m_preset;
        end else if (ld >= 0) begin
            el = e - ld;
            if (el <= n + 1 && !en) ld = -1;
            else if (el <= n) m_count = 32'(n - el);
            else if (el == n + 1) begin m_flag = 1; hold = 1; end
            else begin
                ld = -1;
                if (md1) begin m_flag = 0; arm = e + 1; end
                else begin m_ctrl[0] = 0; hold = 1; end
            end
        end else if (en) arm = e + 1;
        if (WE && Addr == 2'd0) begin
            m_ctrl = Din[3:0];
            if (Din[0] && !hold) m_flag = 0;
        end
        if (WE && Addr == 2'd1) m_preset = Din;
`ifdef TC_STATUS_EN
        if (WE && Addr == 2'd3 && Din[0] && !hold) m_flag = 0;
`endif
    endtask

    function automatic logic [31:0] exp_dout(logic [1:0] a);
        case (a)
            2'd0: return {28'b0, m_ctrl};
            2'd1: return m_preset;
            2'd2: return m_count;
`ifdef TC_STATUS_EN
            default: return {31'b0, m_flag};
`else
            default: return 32'b0;
`endif
        endcase
    endfunction

    task automatic cyc(bit we_i, logic [1:0] a, logic [31:0] d, bit r);
        exp_t x;
        @(posedge clk);
        if (!reset) model_step();
        #1;
        WE = we_i; Addr = a; Din = d;
        if (r) begin reset = 1'b1; model_reset(); end
        else reset = 1'b0;
        x.addr = a; x.dout = exp_dout(a); x.irq = m_flag & m_ctrl[3];
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                vectors++;
                if (Dout !== x.dout) begin
                    miscompares++;
                    $display("FAIL dout addr=%0d at %0t: got %h expected %h", x.addr, $time, Dout, x.dout);
                end
                vectors++;
                if (IRQ !== x.irq) begin
                    miscompares++;
                    $display("FAIL irq at %0t: got %b expected %b", $time, IRQ, x.irq);
                end
            end
        end
    end

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        e = 0;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(0, 2'(i), 32'hFFFF_FFFF, 1);
        // mode 0 expiry, sticky IRQ, En auto-clear
        cyc(1, 1, 5, 0);
        cyc(1, 0, 32'h9, 0);
        repeat (12) cyc(0, 2, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // CTRL rewrite exactly in the INT cycle
        cyc(1, 0, 32'h9, 0);
        repeat (8) cyc(0, 2, 0, 0);
        cyc(1, 0, 32'h9, 0);
        repeat (6) cyc(0, 3, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        // mode 1 auto-reload
        cyc(1, 0, 0, 0);
        cyc(1, 1, 3, 0);
        cyc(1, 0, 32'hB, 0);
        repeat (20) cyc(0, 2, 0, 0);
        // pause at COUNT=4 with IM=0, then re-enable
        cyc(1, 0, 0, 0);
        cyc(1, 1, 10, 0);
        cyc(1, 0, 32'h1, 0);
        repeat (8) cyc(0, 2, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 2, 0, 0);
        cyc(1, 0, 32'h1, 0);
        repeat (4) cyc(0, 2, 0, 0);
        // PRESET=0 expiry, STATUS read, COUNT write ignored, W1C
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 32'h9, 0);
        repeat (6) cyc(0, 3, 0, 0);
        cyc(1, 2, 32'h77, 0);
        cyc(0, 2, 0, 0);
        cyc(1, 3, 32'h1, 0);
        repeat (3) cyc(0, 3, 0, 0);
        // reset mid-count after IRQ was raised
        cyc(1, 1, 2, 0);
        cyc(1, 0, 32'hB, 0);
        repeat (5) cyc(0, 2, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            a = 2'($urandom);
            if (a == 2'd1) d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 12));
            else d = 32'($urandom_range(0, 31)) | 32'($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 3) == 0, a, d, $urandom_range(0, 399) == 0);
        end
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
